instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Accepts the 32-bit fetch address produced by the PC each cycle and issues a word read to instruction memory using a req/ack handshake with variable latency.
- Buffers returned instructions, each tagged with its address, in a small FIFO and presents them to decode with valid/ready.
- A branch redirect (flush) discards all buffered entries and any in-flight reads.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, at least 2.
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction word width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- pc_addr  in  ADDR_W  fetch address from PC.
- pc_valid  in  1  pc_addr is valid this cycle.
- pc_ready  out  1  address is accepted on this edge when pc_valid is also high.
- flush  in  1  branch redirect; discards buffered and in-flight fetches.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  ADDR_W  read address; held stable while mem_req is high.
- mem_ack  in  1  read complete; mem_rdata is valid this cycle.
- mem_rdata  in  DATA_W  read data.
- inst_valid  out  1  head FIFO entry is valid.
- inst_word  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  address of the head instruction.
- inst_fault  out  1  head entry is a misalignment fault.
- decode_ready  in  1  decode consumes the head entry this cycle.

Behaviour:
- Reset:
  - Applies when reset_n is low at a posedge, including mid-transaction.
  - State goes to IDLE and the FIFO empties.
  - Outputs: mem_req=0, mem_addr=0, inst_valid=0, inst_word=0, inst_pc=0, inst_fault=0.
  - pc_ready=0 while in reset.
  - An outstanding memory read is abandoned; memory must tolerate this.
- FSM states: IDLE, REQ, DISCARD.
- IDLE:
  - pc_ready = !flush && (count < DEPTH).
  - On accept with pc_addr[1:0]==0: latch mem_addr=pc_addr and move to REQ. mem_req is registered, so it rises the cycle after accept.
  - On accept with pc_addr[1:0]!=0: no memory access; push {word=NOP_WORD, pc=pc_addr, fault=1} next edge; stay IDLE.
- REQ:
  - mem_req=1 and pc_ready=0.
  - On mem_ack without flush: push {mem_rdata, mem_addr, fault=0}, drop mem_req, go to IDLE.
  - On flush without mem_ack: go to DISCARD, keeping mem_req and mem_addr unchanged.
  - On flush and mem_ack in the same cycle: drop the data and go to IDLE.
- DISCARD:
  - mem_req stays at 1 and pc_ready=0.
  - On mem_ack: data is dropped, mem_req goes to 0, go to IDLE.
  - A further flush has no additional effect.
- mem_ack is ignored in IDLE.
- Slot reservation: an address is accepted only if count < DEPTH, and at most one read is outstanding, so a push can never overflow.
- FIFO:
  - Pop when inst_valid && decode_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - The head entry is driven combinationally from storage.
- Flush priority:
  - flush clears the FIFO (count=0) on that edge and overrides any push or pop in the same cycle.
  - inst_valid is 0 on the cycle after a flush.
- Latency:
  - Accept at cycle N, then mem_req is high from N+1.
  - mem_ack at cycle M ≥ N+1, then the entry is visible at M+1 if the FIFO was empty.
  - Minimum accept-to-inst_valid latency is 2 cycles.
- Throughput: one fetch per (memory latency + 1) cycles, since there is no pipelined request overlap.

Decomposition:
- Package arm_lp_fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, DISCARD}.
  - NOP_WORD = 32'hD503201F.
  - WORD_ALIGN_MASK = 2'b11.
- Sub-module fetch_fifo:
  - Parameterised by DEPTH and entry width (DATA_W+ADDR_W+1).
  - Ports: push/pop/flush inputs, head outputs, count output.
  - Owns pointers and wrap logic.
- The top level contains the FSM, the alignment check and the memory handshake.

Test Plan:
- Basic fetch: reset, then pc_addr=0x100 accepted at N; mem_ack at N+3 with rdata=0x8B020020; decode_ready=1 → inst_valid at N+4, inst_word=0x8B020020, inst_pc=0x100, inst_fault=0.
- Backpressure/full (DEPTH=2): decode_ready=0; fetch 0x0 and 0x4 with 0-wait acks → pc_ready=0 with count=2 and no third mem_req. Then assert decode_ready for one cycle → head 0x0 pops and pc_ready returns to 1.
- Flush mid-request: accept 0x200; assert flush 1 cycle into REQ; mem_ack 2 cycles later with 0xDEADBEEF → mem_req held until ack, data dropped, inst_valid stays 0, FSM back in IDLE.
- Flush with FIFO holding 2 entries and decode_ready=1 on the same cycle → count=0 next cycle, no entry delivered, pc_ready=1.
- Misaligned: pc_addr=0x102 → no mem_req ever asserted; next cycle inst_valid=1, inst_fault=1, inst_word=0xD503201F, inst_pc=0x102.
- Reset mid-REQ: reset_n=0 for one edge while mem_req=1 → mem_req=0, inst_valid=0, state IDLE; a later stray mem_ack is ignored.

Source files
------------

// File: rtl/arm_lp_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, the NOP used for fault entries and the alignment check.
package arm_lp_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD        = 32'hD503201F;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO that buffers fetched entries for decode.
// Flush empties it and overrides any push or pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // An empty FIFO presents an all-zero head so stale entries never leak to decode.
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: accepts PC addresses, reads instruction memory over req/ack,
// and queues tagged instructions (or misalignment faults) for decode.
module instruction_fetch_unit
  import arm_lp_fetch_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_word,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              decode_ready
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_t       state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic               head_valid;
  logic [ENTRY_W-1:0] head_data;
  logic [CNT_W-1:0]   fifo_count;
  logic               accept;

  // Only accept when a FIFO slot is free, so the single outstanding read can always land.
  assign pc_ready = reset_n && (state_q == IDLE) && !flush && (fifo_count < FULL_COUNT);
  assign accept   = pc_ready && pc_valid;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    push_data  = {mem_rdata, mem_addr_q, 1'b0};
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_word_aligned(pc_addr[1:0])) begin
            mem_addr_d = pc_addr;
            mem_req_d  = 1'b1;
            state_d    = REQ;
          end else begin
            push      = 1'b1;
            push_data = {DATA_W'(NOP_WORD), pc_addr, 1'b1};
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          push      = !flush;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (head_valid && decode_ready),
    .flush      (flush),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = head_valid;
  assign inst_word  = head_data[ENTRY_W-1 -: DATA_W];
  assign inst_pc    = head_data[ADDR_W:1];
  assign inst_fault = head_data[0];

endmodule
